// File: rtl/vga_scanout.sv
`timescale 1ns/1ps
// vga_scanout: QVGA framebuffer scanned out as 640x480@60 VGA with 2x2
// pixel doubling. Ports: clk_pix, rst_n, fb_addr/fb_data (1-clk read
// port), vga_r/g/b, vga_hs/vs (active-low), vga_de, frame_start.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_W     = H_ACTIVE / 2,
  parameter int FB_H     = V_ACTIVE / 2,
  parameter int ADDR_W   = $clog2(FB_W * FB_H)
) (
  input  logic              clk_pix,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [15:0]       fb_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP
                         + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP
                         + V_SYNC + V_BP;
  localparam int HC_W = $clog2(H_TOTAL);
  localparam int VC_W = $clog2(V_TOTAL);

  localparam logic [HC_W-1:0] H_ACT =
    HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0] H_LAST =
    HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] HS_BEG =
    HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END =
    HC_W'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VC_W-1:0] V_ACT =
    VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0] V_ACT_M1 =
    VC_W'(V_ACTIVE - 1);
  localparam logic [VC_W-1:0] V_LAST =
    VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] VS_BEG =
    VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END =
    VC_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [ADDR_W-1:0] LINE_STEP =
    ADDR_W'(FB_W);

  logic [HC_W-1:0]   hc_q, hc_d;
  logic [VC_W-1:0]   vc_q, vc_d;
  logic [ADDR_W-1:0] lb_q, lb_d;

  logic vis_c, hs_c, vs_c, fs_c;

  // first delay stage: aligns with fb_data
  logic s1_vis_q, s1_hs_q, s1_vs_q, s1_fs_q;

  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    lb_d = lb_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      if (vc_q == V_LAST) begin
        vc_d = '0;
        lb_d = '0;
      end else begin
        vc_d = vc_q + 1'b1;
        // step the row base only when the next
        // line starts a new framebuffer row
        if (vc_q[0] && (vc_q < V_ACT_M1))
          lb_d = lb_q + LINE_STEP;
      end
    end
  end

  assign vis_c = (hc_q < H_ACT)
               && (vc_q < V_ACT);
  assign hs_c  = (hc_q >= HS_BEG)
               && (hc_q < HS_END);
  assign vs_c  = (vc_q >= VS_BEG)
               && (vc_q < VS_END);
  assign fs_c  = (hc_q == '0)
               && (vc_q == '0);

  assign fb_addr = vis_c
    ? lb_q + ADDR_W'(hc_q[HC_W-1:1])
    : '0;

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      hc_q <= '0;
      vc_q <= '0;
      lb_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      lb_q <= lb_d;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      s1_vis_q <= 1'b0;
      s1_hs_q  <= 1'b1;
      s1_vs_q  <= 1'b1;
      s1_fs_q  <= 1'b0;
    end else begin
      s1_vis_q <= vis_c;
      s1_hs_q  <= ~hs_c;
      s1_vs_q  <= ~vs_c;
      s1_fs_q  <= fs_c;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_de      <= 1'b0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= s1_vis_q
                   ? fb_data[11:8] : 4'h0;
      vga_g       <= s1_vis_q
                   ? fb_data[7:4] : 4'h0;
      vga_b       <= s1_vis_q
                   ? fb_data[3:0] : 4'h0;
      vga_de      <= s1_vis_q;
      vga_hs      <= s1_hs_q;
      vga_vs      <= s1_vs_q;
      frame_start <= s1_fs_q;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
`timescale 1ns/1ps
// tb_vga_scanout: checks a reduced-geometry instance over several frames
// and a full 640x480 instance over its first lines against a model.
module tb_vga_scanout;

  // reduced geometry: 25 x 13 total, 16 x 8 visible, 8 x 4 words
  localparam int SHA = 16, SHFP = 2;
  localparam int SHS = 4,  SHBP = 3;
  localparam int SVA = 8,  SVFP = 1;
  localparam int SVS = 2,  SVBP = 2;
  localparam int SHT = SHA+SHFP+SHS+SHBP;
  localparam int SVT = SVA+SVFP+SVS+SVBP;
  localparam int SFR = SHT * SVT;
  localparam int SAW = 5;

  localparam int FHT = 800, FVT = 525;
  localparam int FAW = 17;

  logic clk_pix = 1'b0;
  logic rst_n   = 1'b0;
  logic ram_ff  = 1'b1;
  logic mon_en  = 1'b0;

  always #20 clk_pix = ~clk_pix;

  logic [SAW-1:0] s_addr;
  logic [15:0]    s_data;
  logic [3:0]     s_r, s_g, s_b;
  logic           s_hs, s_vs, s_de, s_fs;

  logic [FAW-1:0] f_addr;
  logic [15:0]    f_data;
  logic [3:0]     f_r, f_g, f_b;
  logic           f_hs, f_vs, f_de, f_fs;

  vga_scanout #(
    .H_ACTIVE(SHA), .H_FP(SHFP),
    .H_SYNC(SHS),   .H_BP(SHBP),
    .V_ACTIVE(SVA), .V_FP(SVFP),
    .V_SYNC(SVS),   .V_BP(SVBP)
  ) u_small (
    .clk_pix(clk_pix), .rst_n(rst_n),
    .fb_addr(s_addr),  .fb_data(s_data),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
    .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_de(s_de), .frame_start(s_fs)
  );

  vga_scanout u_full (
    .clk_pix(clk_pix), .rst_n(rst_n),
    .fb_addr(f_addr),  .fb_data(f_data),
    .vga_r(f_r), .vga_g(f_g), .vga_b(f_b),
    .vga_hs(f_hs), .vga_vs(f_vs),
    .vga_de(f_de), .frame_start(f_fs)
  );

  int n_chk = 0;
  int n_fail = 0;
  int p = 0;
  int cyc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (p=%0d)",
               tag, obs, exp, p);
    end
  endtask

  function automatic bit m_vis(
    int q, int ht, int vt, int ha, int va);
    int hc = q % ht;
    int vc = (q / ht) % vt;
    return (hc < ha) && (vc < va);
  endfunction

  // word index: two screen pixels and two lines per word
  function automatic logic [31:0] m_addr(
    int q, int ht, int vt, int ha, int va,
    int fbw);
    int hc = q % ht;
    int vc = (q / ht) % vt;
    if (!m_vis(q, ht, vt, ha, va)) return 0;
    return 32'((vc / 2) * fbw + hc / 2);
  endfunction

  // {de, hs, vs, fs, rgb[11:0]} for screen position q
  function automatic logic [15:0] m_out(
    int q, int ht, int vt, int ha, int va,
    int hsb, int hse, int vsb, int vse,
    int fbw);
    int hc, vc;
    logic [31:0] a;
    bit vis;
    if (q < 0) return 16'h6000;
    hc  = q % ht;
    vc  = (q / ht) % vt;
    vis = m_vis(q, ht, vt, ha, va);
    a   = m_addr(q, ht, vt, ha, va, fbw);
    return {vis,
            !(hc >= hsb && hc < hse),
            !(vc >= vsb && vc < vse),
            (hc == 0 && vc == 0),
            vis ? a[11:0] : 12'h000};
  endfunction

  always @(posedge clk_pix) begin
    cyc <= cyc + 1;
    if (!rst_n) p <= 0;
    else        p <= p + 1;
  end

  // 1-clk RAM: word = {random nibble, addr}; garbage when blank
  always @(posedge clk_pix) begin
    if (ram_ff)
      s_data <= 16'hFFFF;
    else if (m_vis(p, SHT, SVT, SHA, SVA))
      s_data <= {4'($urandom), 12'(s_addr)};
    else
      s_data <= 16'($urandom);
  end

  always @(posedge clk_pix) begin
    if (ram_ff)
      f_data <= 16'hFFFF;
    else if (m_vis(p, FHT, FVT, 640, 480))
      f_data <= {4'($urandom), f_addr[11:0]};
    else
      f_data <= 16'($urandom);
  end

  logic [15:0] se, fe;
  int fs_cnt = 0;
  int last_fs = 0;
  bit have_fs = 1'b0;

  always @(negedge clk_pix) begin
    if (mon_en) begin
      se = m_out(p - 2, SHT, SVT, SHA, SVA,
                 18, 22, 9, 11, 8);
      fe = m_out(p - 2, FHT, FVT, 640, 480,
                 656, 752, 490, 492, 320);
      chk("s_addr", 32'(s_addr),
          m_addr(p, SHT, SVT, SHA, SVA, 8));
      chk("s_range", 32'(s_addr < 32), 1);
      chk("s_de", 32'(s_de), 32'(se[15]));
      chk("s_sync", 32'({s_hs, s_vs}),
          32'(se[14:13]));
      chk("s_fs", 32'(s_fs), 32'(se[12]));
      chk("s_rgb", 32'({s_r, s_g, s_b}),
          32'(se[11:0]));
      chk("f_addr", 32'(f_addr),
          m_addr(p, FHT, FVT, 640, 480, 320));
      chk("f_range", 32'(f_addr < 76800), 1);
      chk("f_de", 32'(f_de), 32'(fe[15]));
      chk("f_sync", 32'({f_hs, f_vs}),
          32'(fe[14:13]));
      chk("f_fs", 32'(f_fs), 32'(fe[12]));
      chk("f_rgb", 32'({f_r, f_g, f_b}),
          32'(fe[11:0]));
      if (p == 0) have_fs = 1'b0;
      if (s_fs) begin
        fs_cnt++;
        if (have_fs)
          chk("s_fs_period", 32'(cyc - last_fs),
              32'(SFR));
        have_fs = 1'b1;
        last_fs = cyc;
      end
    end
  end

  int fs_base;

  initial begin
    rst_n  = 1'b0;
    ram_ff = 1'b1;
    @(posedge clk_pix);
    @(negedge clk_pix);
    mon_en = 1'b1;
    repeat (4) @(negedge clk_pix);
    rst_n  = 1'b1;
    ram_ff = 1'b0;
    fs_base = fs_cnt;

    // several small frames, first lines of the full one
    repeat (2600) @(negedge clk_pix);
    chk("fs_count_run1", 32'(fs_cnt - fs_base),
        32'((2600 - 2) / SFR + 1));

    // small instance at line 5, pixel 10
    for (int i = 0; i < SFR + 1; i++) begin
      if ((p % SFR) == 5 * SHT + 10) break;
      @(negedge clk_pix);
    end
    chk("mid_pos", 32'(p % SFR),
        32'(5 * SHT + 10));
    rst_n = 1'b0;
    @(negedge clk_pix);
    rst_n = 1'b1;
    fs_base = fs_cnt;

    repeat (3 * SFR + 20) @(negedge clk_pix);
    chk("fs_count_run2", 32'(fs_cnt - fs_base),
        32'((3 * SFR + 20 - 2) / SFR + 1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
